// File: rtl/io_pkg.sv
// Shared definitions for the UART transmitter I/O block: register addresses,
// STATUS bit positions, FSM state type and small status helpers.
package io_pkg;

    // I/O register addresses
    localparam logic [3:0] IO_UART_DATA = 4'h0;
    localparam logic [3:0] IO_UART_STAT = 4'h1;
    localparam logic [3:0] IO_UART_DIV  = 4'h2;

    // STATUS register bit positions
    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // The count field is only three bits wide; clamp so an 8-deep FIFO
    // reads as 7 rather than wrapping to 0.
    function automatic logic [2:0] sat_count(input logic [3:0] cnt);
        logic [2:0] res;
        if (cnt > 4'd7) begin
            res = 3'd7;
        end else begin
            res = cnt[2:0];
        end
        return res;
    endfunction

    // Assemble the STATUS byte from its individual flags.
    function automatic logic [7:0] pack_status(input logic       empty,
                                               input logic       full,
                                               input logic       busy,
                                               input logic       ovf,
                                               input logic [2:0] cnt);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        s[STAT_BUSY]  = busy;
        s[STAT_OVF]   = ovf;
        s[STAT_CNT_HI:STAT_CNT_LO] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// Small synchronous FIFO. A push is accepted when not full or when a pop
// happens in the same cycle; a pop is accepted when not empty. Pointers wrap
// naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == CW'(1'b0));
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= AW'(1'b0);
            rd_ptr_q <= AW'(1'b0);
            count_q  <= CW'(1'b0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, programmable
// baud divisor (each bit lasts DIV+1 clocks) and a sticky overflow flag.
module io_uart_tx
    import io_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd27
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] io_data,
    input  logic [3:0] io_addr,
    input  logic       io_oe,
    input  logic       io_we,
    output logic       tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // bus-side registers
    logic       io_we_q;
    logic       io_oe_q;
    logic [7:0] div_q;
    logic [7:0] div_d;
    logic       ovf_q;
    logic       ovf_d;

    // serializer registers
    uart_state_t state_q;
    logic [7:0]  shreg_q;
    logic [2:0]  idx_q;
    logic [7:0]  cnt_q;
    logic [7:0]  div_lat_q;
    logic        tx_q;

    // FIFO interface
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_dout_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             push_s;
    logic             pop_s;

    // decode
    logic       we_pulse_s;
    logic       stat_rd_pulse_s;
    logic       drop_s;
    logic       bit_end_s;
    logic       drive_s;
    logic [7:0] rd_data_s;

    assign we_pulse_s      = io_we & ~io_we_q;
    assign stat_rd_pulse_s = io_oe & ~io_oe_q & (io_addr == IO_UART_STAT);
    assign bit_end_s       = (cnt_q == div_lat_q);
    assign push_s          = we_pulse_s & (io_addr == IO_UART_DATA) & (~fifo_full_s | pop_s);
    assign drop_s          = we_pulse_s & (io_addr == IO_UART_DATA) & fifo_full_s & ~pop_s;
    assign tx              = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (io_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Pop the head when idle, or at the end of a stop bit for back-to-back frames.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            IDLE: begin
                pop_s = ~fifo_empty_s;
            end
            STOP: begin
                if (bit_end_s) begin
                    pop_s = ~fifo_empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Next values of DIV and the sticky overflow flag; a drop wins over a clear.
    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (we_pulse_s && (io_addr == IO_UART_DIV)) begin
            div_d = io_data;
        end else begin
            div_d = div_q;
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (stat_rd_pulse_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Bus strobe history, divisor and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_we_q <= 1'b0;
            io_oe_q <= 1'b0;
            div_q   <= DIV_RESET;
            ovf_q   <= 1'b0;
        end else begin
            io_we_q <= io_we;
            io_oe_q <= io_oe;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

    // Serializer FSM: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= 8'h00;
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            div_lat_q <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop_s) begin
                        shreg_q   <= fifo_dout_s;
                        div_lat_q <= div_q;
                        cnt_q     <= 8'd0;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        cnt_q   <= 8'd0;
                        idx_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_q <= 8'd0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shreg_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_q <= 8'd0;
                        if (pop_s) begin
                            shreg_q   <= fifo_dout_s;
                            div_lat_q <= div_q;
                            state_q   <= START;
                            tx_q      <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Read-data mux for the three readable addresses.
    always_comb begin
        rd_data_s = 8'h00;
        case (io_addr)
            IO_UART_DATA: rd_data_s = 8'h00;
            IO_UART_STAT: rd_data_s = pack_status(fifo_empty_s, fifo_full_s,
                                                  (state_q != IDLE), ovf_q,
                                                  sat_count(4'(fifo_count_s)));
            IO_UART_DIV:  rd_data_s = div_q;
            default:      rd_data_s = 8'h00;
        endcase
    end

    assign drive_s = io_oe & ~reset &
                     ((io_addr == IO_UART_DATA) || (io_addr == IO_UART_STAT) ||
                      (io_addr == IO_UART_DIV));
    assign io_data = drive_s ? rd_data_s : 8'bzzzz_zzzz;

endmodule
